// File: rtl/uart_rx_frame.sv
// uart_rx_frame: configurable UART receiver with majority-vote sampling, error flags and ready/valid output
module uart_rx_frame #(
    parameter int CLK_FREQUENCY_HZ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 break_detect
);
    localparam int BIT_TICKS = CLK_FREQUENCY_HZ / BAUD_RATE;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS);
    localparam int IW        = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK_WAIT} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_s0, r_s1, r_allz, r_perr, r_ferr, r_done;
    logic                   w_rx, w_vote, w_mid;

    assign w_rx   = r_sync[SYNC_STAGES-1];
    assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_mid  = r_cnt == CW'(HALF + 1);

    always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    // The tick counter free-runs across bits; every state votes at HALF+1 of its own bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_allz       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_done       <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            break_detect <= 1'b0;
            r_cnt        <= (r_cnt == CW'(BIT_TICKS - 1)) ? '0 : r_cnt + 1'b1;
            if (r_cnt == CW'(HALF - 1)) r_s0 <= w_rx;
            if (r_cnt == CW'(HALF)) r_s1 <= w_rx;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) r_state <= START;
                end
                START: if (w_mid) begin
                    r_state <= w_vote ? IDLE : DATA;
                    r_idx   <= '0;
                    r_allz  <= 1'b1;
                    r_perr  <= 1'b0;
                    r_ferr  <= 1'b0;
                end
                DATA: if (w_mid) begin
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    r_allz  <= r_allz & ~w_vote;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IW'(DATA_BITS - 1)) begin
                        r_idx   <= '0;
                        r_state <= (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: if (w_mid) begin
                    r_perr  <= (^{r_shift, w_vote}) ^ (PARITY == 1);
                    r_allz  <= r_allz & ~w_vote;
                    r_state <= STOP;
                end
                STOP: if (w_mid) begin
                    r_idx  <= r_idx + 1'b1;
                    r_ferr <= r_ferr | ~w_vote;
                    if (r_idx == '0 && r_allz && !w_vote) begin
                        break_detect <= 1'b1;
                        r_state      <= BREAK_WAIT;
                    end else if (r_idx == IW'(STOP_BITS - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                BREAK_WAIT: if (w_rx) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data          <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= r_done & data_valid & ~data_ready;
            if (r_done && (!data_valid || data_ready)) begin
                data          <= r_shift;
                parity_error  <= r_perr;
                framing_error <= r_ferr;
                data_valid    <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: four receiver configurations driven by directed and random frames against a frame-level model
module tb_uart_rx_frame;
    localparam int BT = 10;
    localparam int ND [4] = '{8, 8, 7, 8};
    localparam int PM [4] = '{0, 2, 1, 0};
    localparam int NS [4] = '{1, 1, 1, 2};

    typedef struct {int w; int d; int pe; int fe; int t;} ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b1;
    logic [3:0] rxl = 4'hf;
    wire  [7:0] d0, d1, d3;
    wire  [6:0] d2;
    wire  [3:0] v, pe, fe, ov, bk;
    int         cyc = 0, n_chk = 0, n_err = 0;
    int         n_ov [4], n_bk [4], n_vhi [4];
    logic [3:0] pv = 4'h0;
    logic       pr = 1'b0;
    ev_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame #(.CLK_FREQUENCY_HZ(1_000_000), .BAUD_RATE(100_000)) u0 (
        .clk(clk), .rst(rst), .rx(rxl[0]), .data(d0), .data_valid(v[0]), .data_ready(ready),
        .parity_error(pe[0]), .framing_error(fe[0]), .overrun(ov[0]), .break_detect(bk[0]));
    uart_rx_frame #(.CLK_FREQUENCY_HZ(1_000_000), .BAUD_RATE(100_000), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .rx(rxl[1]), .data(d1), .data_valid(v[1]), .data_ready(ready),
        .parity_error(pe[1]), .framing_error(fe[1]), .overrun(ov[1]), .break_detect(bk[1]));
    uart_rx_frame #(.CLK_FREQUENCY_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .rx(rxl[2]), .data(d2), .data_valid(v[2]), .data_ready(ready),
        .parity_error(pe[2]), .framing_error(fe[2]), .overrun(ov[2]), .break_detect(bk[2]));
    uart_rx_frame #(.CLK_FREQUENCY_HZ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .rx(rxl[3]), .data(d3), .data_valid(v[3]), .data_ready(ready),
        .parity_error(pe[3]), .framing_error(fe[3]), .overrun(ov[3]), .break_detect(bk[3]));

    function automatic int dat(input int w);
        case (w)
            0: return int'(d0);
            1: return int'(d1);
            2: return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    // Start edge to first data_valid cycle: sync (2) + IDLE detect (1) + last centre vote + delivery
    function automatic int lat_of(input int w);
        return (ND[w] + (PM[w] != 0 ? 1 : 0) + NS[w]) * BT + BT / 2 + 6;
    endfunction

    function automatic int model_pe(input int w, input int d, input int p);
        int ones;
        ones = $countones(d & ((1 << ND[w]) - 1)) + p;
        return PM[w] == 1 ? int'(ones % 2 == 0) : PM[w] == 2 ? ones % 2 : 0;
    endfunction

    // A new word is a valid cycle not preceded by a still-pending word
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && v[i] && (!pv[i] || pr)) q.push_back('{i, dat(i), int'(pe[i]), int'(fe[i]), cyc});
            if (!rst && v[i]) n_vhi[i]++;
            if (ov[i]) n_ov[i]++;
            if (bk[i]) n_bk[i]++;
        end
        pv = v;
        pr = ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic line(input int w, input logic b, input int n);
        rxl[w] = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int w, input int d, input int p, input int stp, input int g, output int t0);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < ND[w]; i++) b.push_back(d[i]);
        if (PM[w] != 0) b.push_back(p[0]);
        for (int i = 0; i < NS[w]; i++) b.push_back(stp[i]);
        t0 = cyc;
        for (int c = 0; c < b.size() * BT; c++) begin
            rxl[w] = b[c / BT] ^ (c == g);
            @(posedge clk);
            #1;
        end
        rxl[w] = 1'b1;
    endtask

    task automatic expect_word(input string tag, input int w, input int d, input int epe, input int efe, input int t0);
        ev_t e;
        int  k;
        k = 0;
        while (q.size() == 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_present"}, int'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_dut"}, e.w, w);
            chk({tag, "_data"}, e.d, d);
            chk({tag, "_perr"}, e.pe, epe);
            chk({tag, "_ferr"}, e.fe, efe);
            chk({tag, "_lat"}, e.t - t0, lat_of(w));
        end
    endtask

    task automatic frame(input string tag, input int w, input int d, input int p, input int stp, input int g,
                         input int epe, input int efe);
        int t0;
        send(w, d, p, stp, g, t0);
        line(w, 1'b1, 30);
        expect_word(tag, w, d, epe, efe, t0);
    endtask

    initial begin
        int t [3];
        int base_v, base_o, base_b;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", v, 0);
        chk("rst_data", {d0, d1, d2, d3}, 0);
        chk("rst_flags", {pe, fe, ov, bk}, 0);
        rst = 1'b0;
        line(0, 1'b1, 5);

        base_v = n_vhi[0];
        send(0, 'hA5, 0, 1, -1, t[0]);
        send(0, 'h00, 0, 1, -1, t[1]);
        send(0, 'hFF, 0, 1, -1, t[2]);
        line(0, 1'b1, 30);
        expect_word("b2b_a5", 0, 'hA5, 0, 0, t[0]);
        expect_word("b2b_00", 0, 'h00, 0, 0, t[1]);
        expect_word("b2b_ff", 0, 'hFF, 0, 0, t[2]);
        chk("b2b_valid_cycles", n_vhi[0] - base_v, 3);

        frame("even_bad", 1, 'h07, 0, 1, -1, 1, 0);
        frame("even_ok", 1, 'h07, 1, 1, -1, 0, 0);
        frame("odd7_ok", 2, 'h41, 1, 1, -1, 0, 0);

        frame("stop_low", 0, 'h55, 0, 0, -1, 0, 1);
        frame("after_ferr", 0, 'hC3, 0, 1, -1, 0, 0);
        frame("stop2_low", 3, 'h96, 0, 1, -1, 0, 1);

        line(0, 1'b0, 3);
        line(0, 1'b1, 40);
        chk("false_start", q.size(), 0);
        frame("glitch", 0, 'h00, 0, 1, 4 * BT + 6, 0, 0);

        ready = 1'b0;
        base_o = n_ov[0];
        frame("ovr_first", 0, 'h11, 0, 1, -1, 0, 0);
        send(0, 'h22, 0, 1, -1, t[0]);
        line(0, 1'b1, 30);
        chk("ovr_pulse", n_ov[0] - base_o, 1);
        chk("ovr_hold_data", d0, 'h11);
        chk("ovr_hold_valid", v[0], 1);
        chk("ovr_no_word", q.size(), 0);
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_drop", v[0], 0);
        frame("after_ovr", 0, 'h33, 0, 1, -1, 0, 0);

        base_o = n_ov[0];
        base_b = n_bk[0];
        line(0, 1'b0, 15 * BT);
        line(0, 1'b1, 30);
        chk("break_pulse", n_bk[0] - base_b, 1);
        chk("break_no_ovr", n_ov[0] - base_o, 0);
        chk("break_no_word", q.size(), 0);
        frame("after_break", 0, 'h3C, 0, 1, -1, 0, 0);

        line(0, 1'b0, BT);
        line(0, 1'b1, 25);
        rst = 1'b1;
        line(0, 1'b1, 2);
        chk("midrst_out", {d0, v[0], pe[0], fe[0], ov[0], bk[0]}, 0);
        rst = 1'b0;
        line(0, 1'b1, 20);
        chk("midrst_no_word", q.size(), 0);
        frame("after_rst", 0, 'h5A, 0, 1, -1, 0, 0);

        for (int k = 0; k < 12; k++) begin
            int w, d, p, stp, sm;
            w   = k % 4;
            d   = $urandom & ((1 << ND[w]) - 1);
            p   = $urandom_range(0, 1);
            sm  = (1 << NS[w]) - 1;
            stp = $urandom_range(0, sm);
            if (d == 0 && (PM[w] == 0 || p == 0)) stp = stp | 1;
            frame($sformatf("rnd%0d", k), w, d, p, stp, -1, model_pe(w, d, p), int'((stp & sm) != sm));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
